// File: rtl/pacman_input_ctrl_if.sv
// Key/wall inputs and move-step outputs of the pacman input stage.
// The master side drives keys and walls; the slave side is the controller.
interface pacman_input_ctrl_if;
    logic [3:0] key_n;
    logic [3:0] wall;
    logic [2:0] dir_out;
    logic       step;
    logic       req_pend;

    modport master (
        output key_n, wall,
        input  dir_out, step, req_pend
    );
    modport slave (
        input  key_n, wall,
        output dir_out, step, req_pend
    );
endinterface

// File: rtl/pacman_input_ctrl.sv
// Pacman input stage: key sync/debounce, turn-request buffer, tick-paced moves.
// Optional PAUSE_KEY_EN adds a pause_n key that toggles a paused flag.
module pacman_input_ctrl #(
    parameter int TICK_DIV     = 12500000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic               clock,
    input  logic               reset_n,
`ifdef PAUSE_KEY_EN
    input  logic               pause_n,
`endif
    pacman_input_ctrl_if.slave bus
);
    typedef enum logic {IDLE, MOVING} state_e;

    localparam logic [2:0] WAIT = 3'b100;
`ifdef PAUSE_KEY_EN
    localparam int NK = 5;
`else
    localparam int NK = 4;
`endif
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [NK-1:0] raw, press;
    logic [NK-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NK-1:0] pressed_q, pressed_d;
    logic [DW-1:0] cnt_q [NK];
    logic [DW-1:0] cnt_d [NK];
    logic [TW-1:0] tick_q, tick_d;
    logic          step_q, step_d;
    logic          req_pend_q, req_pend_d;
    logic [1:0]    req_dir_q, req_dir_d;
    logic [2:0]    cur_q, cur_d;
    state_e        state_q, state_d;
    logic          run, decide;

`ifdef PAUSE_KEY_EN
    logic paused_q, paused_d;

    assign raw      = {pause_n, bus.key_n};
    assign paused_d = paused_q ^ press[4];
    assign run      = !paused_q;

    always_ff @(posedge clock) begin
        if (!reset_n) paused_q <= 1'b0;
        else          paused_q <= paused_d;
    end
`else
    assign raw = bus.key_n;
    assign run = 1'b1;
`endif

    // Synchronisers hold the inverted (active-high) level so reset means released.
    always_comb begin
        sync1_d   = ~raw;
        sync2_d   = sync1_q;
        pressed_d = pressed_q;
        for (int i = 0; i < NK; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != pressed_q[i]) begin
                if (cnt_q[i] == DB_LAST) pressed_d[i] = sync2_q[i];
                else                     cnt_d[i]     = cnt_q[i] + 1'b1;
            end
        end
        press = pressed_d & ~pressed_q;
    end

    always_comb begin
        decide     = run && (tick_q == TICK_LAST);
        tick_d     = tick_q;
        step_d     = decide;
        state_d    = state_q;
        cur_d      = cur_q;
        req_pend_d = req_pend_q;
        req_dir_d  = req_dir_q;
        if (run) tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        if (decide) begin
            if (req_pend_q && !bus.wall[req_dir_q]) begin
                cur_d      = {1'b0, req_dir_q};
                req_pend_d = 1'b0;
                state_d    = MOVING;
            end else if (state_q == MOVING && bus.wall[cur_q[1:0]]) begin
                cur_d   = WAIT;
                state_d = IDLE;
            end
        end
        // A fresh press outranks consumption, so it waits for the next tick.
        if (press[0]) begin
            req_pend_d = 1'b1;
            req_dir_d  = 2'd0;
        end else if (press[1]) begin
            req_pend_d = 1'b1;
            req_dir_d  = 2'd1;
        end else if (press[2]) begin
            req_pend_d = 1'b1;
            req_dir_d  = 2'd2;
        end else if (press[3]) begin
            req_pend_d = 1'b1;
            req_dir_d  = 2'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            pressed_q  <= '0;
            for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
            tick_q     <= '0;
            step_q     <= 1'b0;
            req_pend_q <= 1'b0;
            req_dir_q  <= 2'd0;
            cur_q      <= WAIT;
            state_q    <= IDLE;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            pressed_q  <= pressed_d;
            for (int i = 0; i < NK; i++) cnt_q[i] <= cnt_d[i];
            tick_q     <= tick_d;
            step_q     <= step_d;
            req_pend_q <= req_pend_d;
            req_dir_q  <= req_dir_d;
            cur_q      <= cur_d;
            state_q    <= state_d;
        end
    end

    assign bus.dir_out  = cur_q;
    assign bus.step     = step_q;
    assign bus.req_pend = req_pend_q;
endmodule
